// File: rtl/alu_sequencer.sv
// Control-side sequencer for the ALU result latch: holds the opcode for the
// execute time, strobes the latch, stores one or two bytes over the shared bus.
module alu_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned ALU_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       flush,
    input  logic       bus_grant,
    output logic [2:0] alu_op,
    output logic       busy,
    output logic       grab,
    output logic       flags_we,
    output logic       bus_req,
    output logic       store_lo,
    output logic       store_hi,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC     = 3'd1,
        S_GRAB     = 3'd2,
        S_WAIT_BUS = 3'd3,
        S_STORE_LO = 3'd4,
        S_STORE_HI = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] ALU_LOAD = 4'(ALU_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_count;
    logic       r_is_mul;
    logic [2:0] r_alu_op;
    logic       w_accept;
    logic       w_opcode_mul;

    // flush in IDLE outranks a simultaneous start
    assign w_opcode_mul = (opcode == OP_MUL);
    assign w_accept     = (r_state == S_IDLE) && start && !flush;
    assign alu_op       = r_alu_op;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_alu_op <= 3'b000;
            r_is_mul <= 1'b0;
            r_count  <= 4'd0;
        end else if (w_accept) begin
            r_alu_op <= opcode;
            r_is_mul <= w_opcode_mul;
            r_count  <= w_opcode_mul ? MUL_LOAD : ALU_LOAD;
        end else if ((r_state == S_EXEC) && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        grab         = 1'b0;
        flags_we     = 1'b0;
        bus_req      = 1'b0;
        store_lo     = 1'b0;
        store_hi     = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (r_count == 4'd0) begin
                    w_next_state = S_GRAB;
                end
            end
            S_GRAB: begin
                // the strobe still fires on a flush; the stale latch is never stored
                grab         = 1'b1;
                flags_we     = 1'b1;
                w_next_state = flush ? S_IDLE : S_WAIT_BUS;
            end
            S_WAIT_BUS: begin
                bus_req = 1'b1;
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (bus_grant) begin
                    w_next_state = S_STORE_LO;
                end
            end
            S_STORE_LO: begin
                // from here on the transfer completes regardless of flush
                bus_req      = 1'b1;
                store_lo     = 1'b1;
                w_next_state = r_is_mul ? S_STORE_HI : S_DONE;
            end
            S_STORE_HI: begin
                bus_req      = 1'b1;
                store_hi     = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized bench for alu_sequencer, checked cycle by cycle
// against a timeline built from the operation's latency rules.
module tb_alu_sequencer;

    localparam int MULC = 4;
    localparam int ALUC = 1;

    logic       clock;
    logic       reset;
    logic       start;
    logic [2:0] opcode;
    logic       flush;
    logic       bus_grant;
    logic [2:0] alu_op;
    logic       busy;
    logic       grab;
    logic       flags_we;
    logic       bus_req;
    logic       store_lo;
    logic       store_hi;
    logic       done;

    int         n_vec;
    int         n_err;
    logic [2:0] m_alu_op;

    alu_sequencer #(.MUL_CYCLES(MULC), .ALU_CYCLES(ALUC)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .opcode   (opcode),
        .flush    (flush),
        .bus_grant(bus_grant),
        .alu_op   (alu_op),
        .busy     (busy),
        .grab     (grab),
        .flags_we (flags_we),
        .bus_req  (bus_req),
        .store_lo (store_lo),
        .store_hi (store_hi),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Vector layout: {busy, grab, flags_we, bus_req, store_lo, store_hi, done, alu_op}
    task automatic chk(input string tag, input int k, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {busy, grab, flags_we, bus_req, store_lo, store_hi, done, alu_op};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    // Timeline of one op: cycles 1..e execute, then grab, then wait cycles up to
    // the one where the grant is seen (wl), then the byte stores and done.
    function automatic logic [9:0] exp_vec(input int k, input bit mul, input int e,
                                           input int wl, input int last,
                                           input logic [2:0] aop);
        logic [6:0] s;
        s = 7'b0;
        if (k > last)                       s = 7'b0000000;
        else if (k <= e)                    s = 7'b1000000;
        else if (k == e + 1)                s = 7'b1110000;
        else if (k <= wl)                   s = 7'b1001000;
        else if (k == wl + 1)               s = 7'b1001100;
        else if (mul && k == wl + 2)        s = 7'b1001010;
        else                                s = 7'b1000001;
        return {s, aop};
    endfunction

    // Runs one op from an IDLE cycle; d = wait cycles before grant, fk = flush
    // cycle (or -1), hammer = keep requesting opcode 3'b011 while busy,
    // rk = cycle in which reset is pulsed asynchronously (or -1).
    task automatic run_op(input string tag, input logic [2:0] op, input int d,
                          input int fk, input bit hammer, input int rk);
        bit mul;
        int e, w0, wl, dn, last;
        mul  = (op == 3'b101);
        e    = mul ? MULC : ALUC;
        w0   = e + 2;
        wl   = w0 + d;
        dn   = mul ? wl + 3 : wl + 2;
        last = (fk >= 1 && fk <= wl) ? fk : dn;
        start     = 1'b1;
        opcode    = op;
        flush     = 1'b0;
        bus_grant = 1'($urandom);
        @(posedge clock); #1;
        m_alu_op = op;
        for (int k = 1; k <= last + 1; k++) begin
            chk(tag, k, exp_vec(k, mul, e, wl, last, m_alu_op));
            if (k == rk) begin
                #2 reset = 1'b0;
                start = 1'b0;
                flush = 1'b0;
                #1;
                m_alu_op = 3'b000;
                chk({tag, "_async_rst"}, k, 10'b0);
                #2 reset = 1'b1;
                @(posedge clock); #1;
                chk({tag, "_post_rst"}, k + 1, 10'b0);
                return;
            end
            if (k <= last) begin
                if (k >= w0 && k < wl)  bus_grant = 1'b0;
                else if (k == wl)       bus_grant = 1'b1;
                else                    bus_grant = 1'($urandom);
                if (k == fk)            flush = 1'b1;
                else if (k > wl)        flush = ($urandom % 3 == 0);
                else                    flush = 1'b0;
                start  = hammer ? 1'b1 : 1'($urandom);
                opcode = hammer ? 3'b011 : 3'($urandom);
                @(posedge clock); #1;
            end
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_alu_op  = 3'b000;
        reset     = 1'b0;
        start     = 1'b0;
        opcode    = 3'b000;
        flush     = 1'b0;
        bus_grant = 1'b0;

        #12;
        chk("reset_state", 0, 10'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("idle_after_reset", 0, 10'b0);

        run_op("add_fast", 3'b000, 0, -1, 1'b0, -1);
        run_op("mul_default", 3'b101, 0, -1, 1'b0, -1);
        run_op("add_late_grant", 3'b000, 6, -1, 1'b0, -1);
        run_op("add_busy_start", 3'b000, 3, -1, 1'b1, -1);
        run_op("mul_flush_exec", 3'b101, 0, 2, 1'b0, -1);
        run_op("mul_flush_grab", 3'b101, 2, MULC + 1, 1'b0, -1);
        run_op("add_flush_wait", 3'b110, 4, ALUC + 3, 1'b0, -1);
        run_op("mul_flush_store", 3'b101, 1, MULC + 4, 1'b0, -1);

        start  = 1'b1;
        flush  = 1'b1;
        opcode = 3'b010;
        @(posedge clock); #1;
        chk("idle_flush_beats_start", 0, {7'b0, m_alu_op});
        @(posedge clock); #1;
        chk("idle_flush_beats_start2", 0, {7'b0, m_alu_op});
        start = 1'b0;
        flush = 1'b0;

        run_op("mul_reset_store_hi", 3'b101, 0, -1, 1'b0, MULC + 4);
        run_op("add_after_reset", 3'b000, 0, -1, 1'b0, -1);

        for (int i = 0; i < 30; i++) begin
            logic [2:0] rop;
            int         rd;
            int         rfk;
            rop = ($urandom % 2 == 0) ? 3'b101 : 3'($urandom);
            rd  = $urandom_range(4, 0);
            rfk = ($urandom % 3 == 0) ? $urandom_range(14, 1) : -1;
            run_op("random", rop, rd, rfk, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
